// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: datapath/memory status in, datapath enables and memory strobes out.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2
);
  logic [OPCODE_W-1:0] opcode;
  logic                Zero;
  logic                mem_ready;
  logic                mem_req;
  logic                MemRead;
  logic                MemWrite;
  logic                IorD;
  logic                IRWrite;
  logic                PCWrite;
  logic [1:0]          PCSrc;
  logic                RegDst;
  logic                RegWrite;
  logic                MemToReg;
  logic                ALUSrc;
  logic [ALUOP_W-1:0]  ALUOp;
  logic                halted;
  logic [1:0]          fault;

  modport master (
    input  opcode, Zero, mem_ready,
    output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
           RegDst, RegWrite, MemToReg, ALUSrc, ALUOp, halted, fault
  );
  modport slave (
    output opcode, Zero, mem_ready,
    input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
           RegDst, RegWrite, MemToReg, ALUSrc, ALUOp, halted, fault
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM with variable-latency memory handshake, illegal-opcode and timeout faults.
// Optional CTRL_PERF_COUNTERS_EN adds cycle_count / instr_count outputs.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUOP_W     = 2
) (
  input  logic Clock,
  input  logic Reset,
  multicycle_control_unit_if.master bus
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT+1);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_HALT = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT, S_FAULT
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt;
  logic [OPCODE_W-1:0] op_q;
  logic                rd_sel;
  logic [1:0]          fault_q;
  logic                mem_st, tmo;

  assign mem_st = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // The cycle in which the counter already shows MEM_TIMEOUT is the last chance for mem_ready.
  assign tmo    = mem_st && !bus.mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    state_nxt    = state;
    bus.mem_req  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IorD     = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSrc    = 2'b00;
    bus.RegDst   = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemToReg = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.ALUOp    = '0;
    bus.halted   = 1'b0;
    bus.fault    = fault_q;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_nxt   = S_DECODE;
        end else if (tmo) state_nxt = S_FAULT;
      end
      S_DECODE: begin
        bus.ALUSrc = 1'b1;
        case (bus.opcode)
          OP_R:          state_nxt = S_EXEC_R;
          OP_ADDI:       state_nxt = S_EXEC_I;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:          state_nxt = S_JUMP;
          OP_NOP:        state_nxt = S_FETCH;
          OP_HALT:       state_nxt = S_HALT;
          default:       state_nxt = S_FAULT;
        endcase
      end
      S_EXEC_R: begin
        bus.ALUOp = ALUOP_W'(2'b10);
        state_nxt = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.ALUSrc = 1'b1;
        state_nxt  = S_WB_ALU;
      end
      S_WB_ALU: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = rd_sel;
        state_nxt    = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.ALUSrc = 1'b1;
        state_nxt  = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) state_nxt = S_WB_MEM;
        else if (tmo)      state_nxt = S_FAULT;
      end
      S_MEM_WR: begin
        bus.mem_req  = 1'b1;
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready) state_nxt = S_FETCH;
        else if (tmo)      state_nxt = S_FAULT;
      end
      S_WB_MEM: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUOp   = ALUOP_W'(2'b01);
        bus.PCSrc   = 2'b01;
        bus.PCWrite = bus.Zero ^ (op_q == OP_BNE);
        state_nxt   = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = 2'b10;
        state_nxt   = S_FETCH;
      end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: state_nxt  = S_FAULT;
      default: state_nxt  = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      op_q     <= '0;
      rd_sel   <= 1'b0;
      fault_q  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= bus.opcode;
      if (state == S_EXEC_R) rd_sel <= 1'b1;
      if (state == S_EXEC_I) rd_sel <= 1'b0;
      // Any state change clears the counter, which covers every entry into a memory state.
      if (state_nxt != state)               wait_cnt <= '0;
      else if (mem_st && !bus.mem_ready)    wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == S_DECODE && state_nxt == S_FAULT) fault_q <= 2'b01;
      if (tmo)                                       fault_q <= 2'b10;
    end
  end

`ifdef CTRL_PERF_COUNTERS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state != S_HALT && state != S_FAULT) cycle_count <= cycle_count + 32'd1;
      if (state == S_DECODE && state_nxt != S_FAULT) instr_count <= instr_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control vectors against hand-computed constants.
module tb_multicycle_control_unit;
  logic Clock, Reset;
  int   checks = 0, errors = 0;

  multicycle_control_unit_if #(.OPCODE_W(4), .ALUOP_W(2)) bus ();

`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_count;
  multicycle_control_unit #(.OPCODE_W(4), .MEM_TIMEOUT(15), .ALUOP_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus),
    .cycle_count(cycle_count), .instr_count(instr_count));
`else
  multicycle_control_unit #(.OPCODE_W(4), .MEM_TIMEOUT(15), .ALUOP_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus));
`endif

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {halted, fault, mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegDst, RegWrite, MemToReg, ALUSrc, ALUOp}
  logic [16:0] obs;
  assign obs = {bus.halted, bus.fault, bus.mem_req, bus.MemRead, bus.MemWrite, bus.IorD,
                bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.RegDst, bus.RegWrite,
                bus.MemToReg, bus.ALUSrc, bus.ALUOp};

  localparam logic [16:0] E_IDLE = 17'b000_00000000000000;
  localparam logic [16:0] E_FW   = 17'b000_11000000000000;
  localparam logic [16:0] E_FR   = 17'b000_11001100000000;
  localparam logic [16:0] E_DEC  = 17'b000_00000000000100;
  localparam logic [16:0] E_EXR  = 17'b000_00000000000010;
  localparam logic [16:0] E_WBR  = 17'b000_00000000110000;
  localparam logic [16:0] E_WBI  = 17'b000_00000000010000;
  localparam logic [16:0] E_MRD  = 17'b000_11010000000000;
  localparam logic [16:0] E_MWR  = 17'b000_10110000000000;
  localparam logic [16:0] E_WBM  = 17'b000_00000000011000;
  localparam logic [16:0] E_BRT  = 17'b000_00000101000001;
  localparam logic [16:0] E_BRN  = 17'b000_00000001000001;
  localparam logic [16:0] E_JMP  = 17'b000_00000110000000;
  localparam logic [16:0] E_HLT  = 17'b100_00000000000000;
  localparam logic [16:0] E_FI   = 17'b001_00000000000000;
  localparam logic [16:0] E_FT   = 17'b010_00000000000000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Compare one cycle's outputs at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [16:0] e);
    @(negedge Clock);
    chk(tag, 32'(obs), 32'(e));
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.opcode = '0;
    bus.Zero = 1'b0;
    bus.mem_ready = 1'b1;
    do_reset();
`ifdef CTRL_PERF_COUNTERS_EN
    @(negedge Clock);
    chk("perf_rst_cyc", cycle_count, 32'd0);
    chk("perf_rst_ins", instr_count, 32'd0);
    @(posedge Clock); #1;
    repeat (3) begin
      bus.opcode = 4'b0111;
      cyc("perf_fetch", E_FR);
      cyc("perf_dec", E_DEC);
    end
    @(negedge Clock);
    chk("perf_instr3", instr_count, 32'd3);
    chk("perf_cyc7", cycle_count, 32'd7);
    do_reset();
`endif
    cyc("rst_idle", E_IDLE);

    // R-type
    bus.opcode = 4'b0000;
    cyc("r_fetch", E_FR);
    cyc("r_dec", E_DEC);
    cyc("r_exec", E_EXR);
    cyc("r_wb", E_WBR);
    // ADDI
    bus.opcode = 4'b0001;
    cyc("i_fetch", E_FR);
    cyc("i_dec", E_DEC);
    cyc("i_exec", E_DEC);
    cyc("i_wb", E_WBI);
    // LW with 3-cycle memory delay on both accesses: 11 cycles
    bus.opcode = 4'b0010;
    bus.mem_ready = 1'b0;
    repeat (3) cyc("lw_fwait", E_FW);
    bus.mem_ready = 1'b1;
    cyc("lw_fetch", E_FR);
    cyc("lw_dec", E_DEC);
    cyc("lw_addr", E_DEC);
    bus.mem_ready = 1'b0;
    repeat (3) cyc("lw_rwait", E_MRD);
    bus.mem_ready = 1'b1;
    cyc("lw_rd", E_MRD);
    cyc("lw_wb", E_WBM);
    // SW; opcode changes after DECODE must not matter
    bus.opcode = 4'b0011;
    cyc("sw_fetch", E_FR);
    cyc("sw_dec", E_DEC);
    bus.opcode = 4'b0010;
    cyc("sw_addr", E_DEC);
    cyc("sw_wr", E_MWR);
    // Branches
    bus.opcode = 4'b0100; bus.Zero = 1'b1;
    cyc("beq1_fetch", E_FR); cyc("beq1_dec", E_DEC); cyc("beq1_br", E_BRT);
    bus.opcode = 4'b0100; bus.Zero = 1'b0;
    cyc("beq0_fetch", E_FR); cyc("beq0_dec", E_DEC); cyc("beq0_br", E_BRN);
    bus.opcode = 4'b0101; bus.Zero = 1'b1;
    cyc("bne1_fetch", E_FR); cyc("bne1_dec", E_DEC); cyc("bne1_br", E_BRN);
    bus.opcode = 4'b0101; bus.Zero = 1'b0;
    cyc("bne0_fetch", E_FR); cyc("bne0_dec", E_DEC); cyc("bne0_br", E_BRT);
    // Jump, NOP
    bus.opcode = 4'b0110;
    cyc("j_fetch", E_FR); cyc("j_dec", E_DEC); cyc("j_jmp", E_JMP);
    bus.opcode = 4'b0111;
    cyc("nop_fetch", E_FR); cyc("nop_dec", E_DEC);
    // Reset in the middle of a memory write wait
    bus.opcode = 4'b0011;
    cyc("swr_fetch", E_FR); cyc("swr_dec", E_DEC); cyc("swr_addr", E_DEC);
    bus.mem_ready = 1'b0;
    cyc("swr_wait", E_MWR);
    Reset = 1'b1;
    cyc("swr_wait_rst", E_MWR);
    Reset = 1'b0;
    cyc("swr_idle", E_IDLE);
    // Illegal opcode
    bus.mem_ready = 1'b1;
    bus.opcode = 4'b1010;
    cyc("ill_fetch", E_FR); cyc("ill_dec", E_DEC);
    repeat (3) cyc("ill_fault", E_FI);
    // HALT
    do_reset();
    cyc("h_idle", E_IDLE);
    bus.opcode = 4'b1111;
    cyc("h_fetch", E_FR); cyc("h_dec", E_DEC);
    repeat (20) cyc("h_halt", E_HLT);
    // Memory timeout in FETCH
    do_reset();
    cyc("t_idle", E_IDLE);
    bus.mem_ready = 1'b0;
    repeat (16) cyc("t_wait", E_FW);
    repeat (2) cyc("t_fault", E_FT);
    // mem_ready on the last allowed wait cycle succeeds
    do_reset();
    cyc("tl_idle", E_IDLE);
    bus.opcode = 4'b0111;
    repeat (15) cyc("tl_wait", E_FW);
    bus.mem_ready = 1'b1;
    cyc("tl_fetch", E_FR);
    cyc("tl_dec", E_DEC);
    cyc("tl_refetch", E_FR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
